// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS-subset control unit, Moore FSM over the datapath.
// Define CTRL_EXCEPTION_EN to add the overflow/undefined-opcode exception path (EXC).
module mc_control_fsm #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
`ifdef CTRL_EXCEPTION_EN
  input  logic       overflow,
  output logic       epc_write,
`endif
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [3:0] state_o
);

  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_WAIT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    ST_RST       = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_R_EXEC    = 4'd7,
    ST_R_WB      = 4'd8,
    ST_ADDI_EXEC = 4'd9,
    ST_ADDI_WB   = 4'd10,
    ST_BRANCH    = 4'd11,
    ST_JUMP      = 4'd12
`ifdef CTRL_EXCEPTION_EN
    , ST_EXC     = 4'd13
`endif
  } state_t;

  state_t        state;
  state_t        nextState;
  logic [CW-1:0] waitCnt;
  logic          waitDone;
  logic          ovfTrap;

`ifdef CTRL_EXCEPTION_EN
  localparam state_t TRAP_ST = ST_EXC;
  assign ovfTrap = overflow;
`else
  // Without the exception path undefined opcodes fall back to FETCH as a nop.
  localparam state_t TRAP_ST = ST_FETCH;
  assign ovfTrap = 1'b0;
`endif

  assign waitDone = (waitCnt == WAIT_MAX);
  assign state_o  = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_RST;
      waitCnt <= '0;
    end else begin
      state <= nextState;
      if (nextState != state)
        waitCnt <= '0;
      else if (!waitDone)
        waitCnt <= waitCnt + 1'b1;
    end
  end

  always_comb begin
    nextState     = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 3'b100;
    alu_op        = 2'b00;
`ifdef CTRL_EXCEPTION_EN
    epc_write     = 1'b0;
`endif
    unique case (state)
      ST_RST: nextState = ST_FETCH;
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 3'b001;
        // IR and PC load only once the memory word is valid.
        if (waitDone) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nextState = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = 3'b011;
        unique case (opcode)
          OP_RTYPE:     nextState = ST_R_EXEC;
          OP_LW, OP_SW: nextState = ST_MEM_ADDR;
          OP_BEQ:       nextState = ST_BRANCH;
          OP_J:         nextState = ST_JUMP;
          OP_ADDI:      nextState = ST_ADDI_EXEC;
          default:      nextState = TRAP_ST;
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 3'b010;
        nextState = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      end
      ST_MEM_READ: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (waitDone)
          nextState = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        nextState  = ST_FETCH;
      end
      ST_MEM_WRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        nextState = ST_FETCH;
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 3'b000;
        alu_op    = 2'b10;
        nextState = ovfTrap ? TRAP_ST : ST_R_WB;
      end
      ST_R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        nextState = ST_FETCH;
      end
      ST_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 3'b010;
        nextState = ovfTrap ? TRAP_ST : ST_ADDI_WB;
      end
      ST_ADDI_WB: begin
        reg_write = 1'b1;
        nextState = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = 3'b000;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        nextState     = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        nextState = ST_FETCH;
      end
`ifdef CTRL_EXCEPTION_EN
      ST_EXC: begin
        // ALU recomputes PC-4 so EPC holds the faulting instruction.
        alu_src_b = 3'b001;
        alu_op    = 2'b01;
        epc_write = 1'b1;
        pc_write  = 1'b1;
        pc_source = 2'b11;
        nextState = ST_FETCH;
      end
`endif
      default: nextState = ST_RST;
    endcase
  end

endmodule
